ro_freq_counter: RTL

//  Measurement end of the ring-oscillator PUF cell: enables one ring oscillator,

---
 rtl/ro_freq_counter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the RO, lets it settle, counts synchronised
// rising edges over window_len clk cycles, then reports count/overflow with a done pulse.
// Build option RO_CNT_SATURATE_EN: count saturates at all-ones instead of wrapping.

module ro_freq_counter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic             ro_in,
    output logic             ro_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > ST_W) ? WIN_W : ST_W;

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    state_t             state, nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [WIN_W-1:0]   win;
    logic               accept;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ro_prev;
    logic                   ro_rise;

    // ro_in is asynchronous; only the last sync stage is ever looked at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            ro_prev <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_in};
            ro_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ro_rise = sync_q[SYNC_STAGES-1] & ~ro_prev;

    always_comb begin
        nxt     = state;
        tmr_nxt = tmr;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    nxt     = SETTLE;
                    tmr_nxt = TMR_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (tmr == '0) begin
                    if (win != '0) begin
                        nxt     = COUNT;
                        tmr_nxt = TMR_W'(win) - TMR_W'(1);
                    end else begin
                        nxt     = DONE;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            COUNT: begin
                if (tmr == '0) nxt = DONE;
                else           tmr_nxt = tmr - TMR_W'(1);
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // ro_enable is registered from next-state so the oscillator enable never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            ro_enable <= 1'b0;
        end else begin
            state     <= nxt;
            tmr       <= tmr_nxt;
            ro_enable <= (nxt == SETTLE) || (nxt == COUNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            win      <= window_len;
            count    <= '0;
            overflow <= 1'b0;
        end else if ((state == COUNT) && ro_rise) begin
            if (&count) begin
                overflow <= 1'b1;
`ifdef RO_CNT_SATURATE_EN
                count    <= count;
`else
                count    <= '0;
`endif
            end else begin
                count    <= count + CNT_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
